hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Read-after-write interlock and bypass controller for the five-stage LoongArch pipeline. It sits beside the decode stage and keeps a shadow record of the destination register held by each in-flight instruction in EXE, MEM and WB. From that record it drives decode's `ds_ready_go`, selects forwarded operands for `rj_value`/`rkd_value`, and counts load-use stall cycles for performance debug.

## Interface
Parameters:
- `STALL_CNT_W`, 32, width of the stall-cycle counter.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `ds_valid`  in  1  decode stage holds a valid instruction.
- `ds_rj`, `ds_rkd`  in  5 each  source register addresses (`rkd` is rd for beq/bne/st.w, rk otherwise).
- `ds_use_rj`, `ds_use_rkd`  in  1 each  source is actually read.
- `ds_gr_we`, `ds_is_load`  in  1 each  decode instruction writes GR; it is ld.w.
- `ds_dest`  in  5  decode destination (r1 for bl).
- `rf_rdata1`, `rf_rdata2`  in  32 each  regfile read data.
- `es_result`  in  32  EXE ALU result.
- `ms_result`  in  32  MEM final result (load data already merged).
- `ws_result`  in  32  WB write data.
- `ds_to_es_fire`, `es_to_ms_fire`, `ms_to_ws_fire`, `ws_retire`  in  1 each  stage-boundary handshakes (valid & allowin).
- `es_flush`  in  1  kill the EXE-slot instruction (branch wrong-path cancel).
- `ds_ready_go`  out  1  decode may issue.
- `rj_value`, `rkd_value`  out  32 each  resolved operands.
- `stall_cycles`  out  `STALL_CNT_W`  saturating count of stall cycles.

## Operation
- Three slot registers, E, M and W. Each holds {valid, gr_we, is_load, dest[4:0]}.
- Slot E update:
  - On `ds_to_es_fire`, load E from the decode fields.
  - Otherwise, clear E.valid on `es_to_ms_fire` or `es_flush`.
  - `es_flush` together with `ds_to_es_fire`: the incoming instruction wins.
- Slot M update:
  - On `es_to_ms_fire`, load M from E. If `es_flush` is asserted the same cycle, M.valid=0.
  - Otherwise, clear M.valid on `ms_to_ws_fire`.
- Slot W update:
  - On `ms_to_ws_fire`, load W from M.
  - Otherwise, clear W.valid on `ws_retire`.
- All slot shifts in one cycle happen simultaneously, using pre-edge values.
- A slot matches source `s` when: valid & gr_we & dest≠0 & dest==s & use_s.
- Operand priority: E > M > W > regfile. The youngest producer wins.
  - E match, not a load: forward `es_result`.
  - M match: forward `ms_result`.
  - W match: forward `ws_result`.
  - No match: pass the regfile data through.
- Load-use stall: `ds_ready_go`=0 when `ds_valid` and either source matches slot E with E.is_load=1. The forwarded value is don't-care while stalled.
- r0 is never matched. A read of r0 returns `rf_rdata` (0).
- `stall_cycles` increments on every cycle where `ds_valid & ~ds_ready_go`, and saturates at all-ones.

## Timing
- Slot updates are registered. Operand mux and `ds_ready_go` are purely combinational from the slots and current inputs; there is no added latency.
- A load issued at cycle t sits in E at t+1. A dependent instruction in decode stalls at t+1 and resolves from M at t+2, so the stall is exactly one cycle when downstream is not stalled.
- A back-pressured EXE holds E unchanged, so the stall persists until `es_to_ms_fire`.
- Reset values: all slots invalid, `stall_cycles`=0. The outputs `ds_ready_go`=1, `rj_value`=`rf_rdata1` and `rkd_value`=`rf_rdata2` follow from the empty slots.
- Reset mid-operation clears all slots regardless of fire inputs the same cycle.
- No loss or duplication of slot contents when every fire input is asserted in the same cycle.

## Structure
- Slot field widths and the bit positions of {valid, gr_we, is_load, dest} are added to `mycpu.h` as defines alongside the existing bus widths.
- One sub-module, `fwd_sel`: the match-and-mux for a single source operand, producing {value, load_hit}. It is instantiated twice, for rj and rkd.
- Slot registers and the counter stay in the top module.

## Test plan
- `add.w r3,r1,r2` then `addi.w r4,r3,5` back to back, with `es_result`=0x10: `rj_value`=0x10, `ds_ready_go`=1, no stall.
- `ld.w r5` then `add.w r6,r5,r0`: one cycle with `ds_ready_go`=0 and `stall_cycles`=1. Next cycle `rj_value`=`ms_result`=0xCAFE.
- r7 written in E (0x1), M (0x2) and W (0x3) simultaneously, and decode reads r7: `rj_value`=0x1. Retire E, M and W in turn and check 0x2, 0x3, then `rf_rdata1`.
- Instruction writing r0 in E with `es_result`=0xFF, decode reads r0: `rj_value`=`rf_rdata1`=0.
- Load in E with `es_flush`=1 and no new issue: E and M stay invalid and a dependent instruction is not stalled. Reset asserted with all fires high: all slots are invalid next cycle and `stall_cycles`=0.
- `stall_cycles` preset to all-ones via a long stall: the counter stays at all-ones with no wrap.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the decode-side RAW interlock and bypass controller.
// A slot mirrors what one downstream stage will eventually write back.
package hazard_scoreboard_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    // Slot layout, MSB first: {valid, gr_we, is_load, dest}
    localparam int SLOT_DEST_LO = 0;
    localparam int SLOT_DEST_HI = SLOT_DEST_LO + REG_W - 1;
    localparam int SLOT_IS_LOAD = SLOT_DEST_HI + 1;
    localparam int SLOT_GR_WE   = SLOT_IS_LOAD + 1;
    localparam int SLOT_VALID   = SLOT_GR_WE + 1;
    localparam int SLOT_W       = SLOT_VALID + 1;

    typedef struct packed {
        logic             valid;
        logic             gr_we;
        logic             is_load;
        logic [REG_W-1:0] dest;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '0;

    // r0 is hardwired to zero, so a producer targeting it never matches.
    function automatic logic slot_match(
        input slot_t            slot,
        input logic [REG_W-1:0] src,
        input logic             use_src
    );
        return slot.valid & slot.gr_we & use_src
             & (slot.dest != '0) & (slot.dest == src);
    endfunction

    function automatic slot_t make_slot(
        input logic             gr_we,
        input logic             is_load,
        input logic [REG_W-1:0] dest
    );
        slot_t s;
        s.valid   = 1'b1;
        s.gr_we   = gr_we;
        s.is_load = is_load;
        s.dest    = dest;
        return s;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_fwd_sel.sv
// Match-and-mux for one decode source operand.
// The youngest in-flight producer wins; a load in EXE cannot forward yet.
module fwd_sel
    import hazard_scoreboard_pkg::*;
(
    input  slot_t             e_slot,
    input  slot_t             m_slot,
    input  slot_t             w_slot,
    input  logic [REG_W-1:0]  src,
    input  logic              use_src,
    input  logic [DATA_W-1:0] rf_rdata,
    input  logic [DATA_W-1:0] es_result,
    input  logic [DATA_W-1:0] ms_result,
    input  logic [DATA_W-1:0] ws_result,
    output logic [DATA_W-1:0] value,
    output logic              load_hit
);

    logic e_hit;
    logic m_hit;
    logic w_hit;

    assign e_hit = slot_match(e_slot, src, use_src);
    assign m_hit = slot_match(m_slot, src, use_src);
    assign w_hit = slot_match(w_slot, src, use_src);

    assign load_hit = e_hit & e_slot.is_load;

    // Hits may overlap, so this is a priority chain, not a parallel case.
    always_comb begin
        value = rf_rdata;
        if (e_hit) begin
            value = es_result;
        end else if (m_hit) begin
            value = ms_result;
        end else if (w_hit) begin
            value = ws_result;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Shadow EXE/MEM/WB destination record driving decode's
// load-use interlock, operand bypass and stall-cycle counter.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ds_valid,
    input  logic [REG_W-1:0]       ds_rj,
    input  logic [REG_W-1:0]       ds_rkd,
    input  logic                   ds_use_rj,
    input  logic                   ds_use_rkd,
    input  logic                   ds_gr_we,
    input  logic                   ds_is_load,
    input  logic [REG_W-1:0]       ds_dest,
    input  logic [DATA_W-1:0]      rf_rdata1,
    input  logic [DATA_W-1:0]      rf_rdata2,
    input  logic [DATA_W-1:0]      es_result,
    input  logic [DATA_W-1:0]      ms_result,
    input  logic [DATA_W-1:0]      ws_result,
    input  logic                   ds_to_es_fire,
    input  logic                   es_to_ms_fire,
    input  logic                   ms_to_ws_fire,
    input  logic                   ws_retire,
    input  logic                   es_flush,
    output logic                   ds_ready_go,
    output logic [DATA_W-1:0]      rj_value,
    output logic [DATA_W-1:0]      rkd_value,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    slot_t e_slot;
    slot_t m_slot;
    slot_t w_slot;

    logic rj_load_hit;
    logic rkd_load_hit;
    logic stall;

    // All three slots shift on the same edge from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_slot <= SLOT_EMPTY;
            m_slot <= SLOT_EMPTY;
            w_slot <= SLOT_EMPTY;
        end else begin
            if (ds_to_es_fire) begin
                e_slot <= make_slot(ds_gr_we, ds_is_load, ds_dest);
            end else if (es_to_ms_fire || es_flush) begin
                e_slot.valid <= 1'b0;
            end

            if (es_to_ms_fire) begin
                m_slot       <= e_slot;
                m_slot.valid <= e_slot.valid & ~es_flush;
            end else if (ms_to_ws_fire) begin
                m_slot.valid <= 1'b0;
            end

            if (ms_to_ws_fire) begin
                w_slot <= m_slot;
            end else if (ws_retire) begin
                w_slot.valid <= 1'b0;
            end
        end
    end

    fwd_sel u_fwd_rj (
        .e_slot    (e_slot),
        .m_slot    (m_slot),
        .w_slot    (w_slot),
        .src       (ds_rj),
        .use_src   (ds_use_rj),
        .rf_rdata  (rf_rdata1),
        .es_result (es_result),
        .ms_result (ms_result),
        .ws_result (ws_result),
        .value     (rj_value),
        .load_hit  (rj_load_hit)
    );

    fwd_sel u_fwd_rkd (
        .e_slot    (e_slot),
        .m_slot    (m_slot),
        .w_slot    (w_slot),
        .src       (ds_rkd),
        .use_src   (ds_use_rkd),
        .rf_rdata  (rf_rdata2),
        .es_result (es_result),
        .ms_result (ms_result),
        .ws_result (ws_result),
        .value     (rkd_value),
        .load_hit  (rkd_load_hit)
    );

    assign stall       = ds_valid & (rj_load_hit | rkd_load_hit);
    assign ds_ready_go = ~stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (stall && !(&stall_cycles)) begin
            stall_cycles <= stall_cycles + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed and random checks of hazard_scoreboard against
// a per-stage reference model of the in-flight producers.
module tb_hazard_scoreboard;

    localparam int W = 4;
    localparam int CMAX = (1 << W) - 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        ds_valid;
    logic [4:0]  ds_rj;
    logic [4:0]  ds_rkd;
    logic        ds_use_rj;
    logic        ds_use_rkd;
    logic        ds_gr_we;
    logic        ds_is_load;
    logic [4:0]  ds_dest;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic [31:0] es_result;
    logic [31:0] ms_result;
    logic [31:0] ws_result;
    logic        ds_to_es_fire;
    logic        es_to_ms_fire;
    logic        ms_to_ws_fire;
    logic        ws_retire;
    logic        es_flush;
    logic        ds_ready_go;
    logic [31:0] rj_value;
    logic [31:0] rkd_value;
    logic [W-1:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    // Model: index 0 = EXE, 1 = MEM, 2 = WB
    logic       mv [3];
    logic       mwe[3];
    logic       mld[3];
    logic [4:0] md [3];
    int         mcnt;

    always #5 clk = ~clk;

    hazard_scoreboard #(.STALL_CNT_W(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .ds_valid      (ds_valid),
        .ds_rj         (ds_rj),
        .ds_rkd        (ds_rkd),
        .ds_use_rj     (ds_use_rj),
        .ds_use_rkd    (ds_use_rkd),
        .ds_gr_we      (ds_gr_we),
        .ds_is_load    (ds_is_load),
        .ds_dest       (ds_dest),
        .rf_rdata1     (rf_rdata1),
        .rf_rdata2     (rf_rdata2),
        .es_result     (es_result),
        .ms_result     (ms_result),
        .ws_result     (ws_result),
        .ds_to_es_fire (ds_to_es_fire),
        .es_to_ms_fire (es_to_ms_fire),
        .ms_to_ws_fire (ms_to_ws_fire),
        .ws_retire     (ws_retire),
        .es_flush      (es_flush),
        .ds_ready_go   (ds_ready_go),
        .rj_value      (rj_value),
        .rkd_value     (rkd_value),
        .stall_cycles  (stall_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Returns {load_in_exe, value}; scans youngest producer first.
    function automatic logic [32:0] ref_fwd(input logic [4:0] src,
                                            input logic use_s,
                                            input logic [31:0] rf);
        logic [31:0] res[3];
        res[0] = es_result;
        res[1] = ms_result;
        res[2] = ws_result;
        if (!use_s || src == 5'd0) return {1'b0, rf};
        for (int s = 0; s < 3; s++) begin
            if (mv[s] && mwe[s] && md[s] == src)
                return {(s == 0) && mld[s], res[s]};
        end
        return {1'b0, rf};
    endfunction

    function automatic logic ref_go();
        logic [32:0] a;
        logic [32:0] b;
        a = ref_fwd(ds_rj, ds_use_rj, rf_rdata1);
        b = ref_fwd(ds_rkd, ds_use_rkd, rf_rdata2);
        return !(ds_valid && (a[32] || b[32]));
    endfunction

    task automatic settle();
        logic [32:0] a;
        logic [32:0] b;
        logic go;
        #1;
        a = ref_fwd(ds_rj, ds_use_rj, rf_rdata1);
        b = ref_fwd(ds_rkd, ds_use_rkd, rf_rdata2);
        go = ref_go();
        chk("ready_go", {31'd0, ds_ready_go}, {31'd0, go});
        if (go && !a[32]) chk("rj_value", rj_value, a[31:0]);
        if (go && !b[32]) chk("rkd_value", rkd_value, b[31:0]);
        chk("stall_cycles", {28'd0, stall_cycles}, mcnt);
    endtask

    task automatic clock();
        logic ov[3];
        logic owe[3];
        logic old[3];
        logic [4:0] od[3];
        logic go;
        go = ref_go();
        for (int s = 0; s < 3; s++) begin
            ov[s] = mv[s]; owe[s] = mwe[s]; old[s] = mld[s]; od[s] = md[s];
        end
        if (reset) begin
            for (int s = 0; s < 3; s++) mv[s] = 1'b0;
            mcnt = 0;
        end else begin
            if (ms_to_ws_fire) begin
                mv[2] = ov[1]; mwe[2] = owe[1]; mld[2] = old[1]; md[2] = od[1];
            end else if (ws_retire) mv[2] = 1'b0;
            if (es_to_ms_fire) begin
                mv[1] = ov[0] && !es_flush;
                mwe[1] = owe[0]; mld[1] = old[0]; md[1] = od[0];
            end else if (ms_to_ws_fire) mv[1] = 1'b0;
            if (ds_to_es_fire) begin
                mv[0] = 1'b1; mwe[0] = ds_gr_we;
                mld[0] = ds_is_load; md[0] = ds_dest;
            end else if (es_to_ms_fire || es_flush) mv[0] = 1'b0;
            if (!go && mcnt < CMAX) mcnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        settle();
        clock();
    endtask

    task automatic idle();
        reset = 0; ds_valid = 0; ds_rj = 0; ds_rkd = 0;
        ds_use_rj = 0; ds_use_rkd = 0; ds_gr_we = 0; ds_is_load = 0;
        ds_dest = 0; rf_rdata1 = 0; rf_rdata2 = 0; es_result = 0;
        ms_result = 0; ws_result = 0; ds_to_es_fire = 0;
        es_to_ms_fire = 0; ms_to_ws_fire = 0; ws_retire = 0; es_flush = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        step();
        reset = 0;
    endtask

    task automatic issue(input logic [4:0] d, input logic ld);
        ds_to_es_fire = 1; ds_gr_we = 1; ds_is_load = ld; ds_dest = d;
    endtask

    task automatic read_rj(input logic [4:0] r);
        ds_valid = 1; ds_rj = r; ds_use_rj = 1;
    endtask

    initial begin
        for (int s = 0; s < 3; s++) begin
            mv[s] = 0; mwe[s] = 0; mld[s] = 0; md[s] = 0;
        end
        mcnt = 0;
        idle();
        reset = 1;
        clock();
        reset = 0;

        // Reset state: empty slots pass regfile data through
        read_rj(5'd3); ds_rkd = 5'd4; ds_use_rkd = 1;
        rf_rdata1 = 32'h1234; rf_rdata2 = 32'h5678; es_result = 32'hDEAD;
        settle();
        chk("rst_go", {31'd0, ds_ready_go}, 32'd1);
        chk("rst_rj", rj_value, 32'h1234);
        chk("rst_rkd", rkd_value, 32'h5678);
        chk("rst_cnt", {28'd0, stall_cycles}, 32'd0);
        clock();

        // add r3 then addi r4,r3,5: forwarded from EXE, no stall
        idle(); issue(5'd3, 0); step();
        idle(); read_rj(5'd3); es_result = 32'h10;
        settle();
        chk("alu_fwd", rj_value, 32'h10);
        chk("alu_go", {31'd0, ds_ready_go}, 32'd1);
        clock();

        // ld r5 then add r6,r5,r0: single stall cycle, then from MEM
        do_reset();
        idle(); issue(5'd5, 1); step();
        idle(); read_rj(5'd5); ds_rkd = 5'd0; ds_use_rkd = 1;
        settle();
        chk("lu_stall", {31'd0, ds_ready_go}, 32'd0);
        es_to_ms_fire = 1; clock();
        idle(); read_rj(5'd5); ms_result = 32'hCAFE;
        settle();
        chk("lu_go", {31'd0, ds_ready_go}, 32'd1);
        chk("lu_cnt", {28'd0, stall_cycles}, 32'd1);
        chk("lu_fwd", rj_value, 32'hCAFE);
        clock();

        // r7 in all three slots; peel them off youngest first
        do_reset();
        idle(); issue(5'd7, 0); step();
        idle(); issue(5'd7, 0); es_to_ms_fire = 1; step();
        idle(); issue(5'd7, 0); es_to_ms_fire = 1; ms_to_ws_fire = 1; step();
        idle(); read_rj(5'd7); rf_rdata1 = 32'h77;
        es_result = 1; ms_result = 2; ws_result = 3;
        settle(); chk("prio_e", rj_value, 32'h1);
        es_flush = 1; clock(); es_flush = 0;
        settle(); chk("prio_m", rj_value, 32'h2);
        ms_to_ws_fire = 1; clock(); ms_to_ws_fire = 0;
        settle(); chk("prio_w", rj_value, 32'h3);
        ws_retire = 1; clock(); ws_retire = 0;
        settle(); chk("prio_rf", rj_value, 32'h77);
        clock();

        // writer of r0 never forwards
        do_reset();
        idle(); issue(5'd0, 0); step();
        idle(); read_rj(5'd0); es_result = 32'hFF;
        settle(); chk("r0_rj", rj_value, 32'h0);
        clock();

        // flushed load moving to MEM leaves no hazard behind
        do_reset();
        idle(); issue(5'd5, 1); step();
        idle(); es_flush = 1; es_to_ms_fire = 1; step();
        idle(); read_rj(5'd5); rf_rdata1 = 32'hABC; ms_result = 32'h99;
        settle();
        chk("flush_go", {31'd0, ds_ready_go}, 32'd1);
        chk("flush_rj", rj_value, 32'hABC);
        clock();

        // reset beats every fire input in the same cycle
        idle(); issue(5'd5, 1); step();
        idle(); read_rj(5'd5); step();
        reset = 1; issue(5'd5, 1); es_to_ms_fire = 1;
        ms_to_ws_fire = 1; ws_retire = 1; step();
        idle(); read_rj(5'd5); rf_rdata1 = 32'h55;
        settle();
        chk("rst_all_go", {31'd0, ds_ready_go}, 32'd1);
        chk("rst_all_cnt", {28'd0, stall_cycles}, 32'd0);
        chk("rst_all_rj", rj_value, 32'h55);
        clock();

        // long stall saturates the counter
        idle(); issue(5'd9, 1); step();
        idle(); read_rj(5'd9);
        for (int i = 0; i < CMAX + 6; i++) step();
        settle();
        chk("sat_cnt", {28'd0, stall_cycles}, CMAX);
        clock();

        // random traffic with a small register window
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            ds_valid = $urandom_range(0, 3) != 0;
            ds_rj = 5'($urandom_range(0, 3));
            ds_rkd = 5'($urandom_range(0, 3));
            ds_use_rj = $urandom_range(0, 3) != 0;
            ds_use_rkd = $urandom_range(0, 1) != 0;
            ds_gr_we = $urandom_range(0, 3) != 0;
            ds_is_load = $urandom_range(0, 2) == 0;
            ds_dest = 5'($urandom_range(0, 3));
            rf_rdata1 = $urandom; rf_rdata2 = $urandom;
            es_result = $urandom; ms_result = $urandom; ws_result = $urandom;
            ds_to_es_fire = $urandom_range(0, 1) != 0;
            es_to_ms_fire = $urandom_range(0, 2) != 0;
            ms_to_ws_fire = $urandom_range(0, 2) != 0;
            ws_retire = $urandom_range(0, 1) != 0;
            es_flush = $urandom_range(0, 7) == 0;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
